// File: rtl/ser_par_conv_hs.sv
// Serial-to-parallel converter with a valid/ready holding register on the
// output. Collects WIDTH qualified serial bits into a word, presents it on
// data_out, and flags words that complete while the previous one is still
// waiting to be accepted.
module ser_par_conv_hs #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             en,
  input  logic             clr,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             busy,
  output logic             overrun
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  // Shift register value after absorbing the current data_in bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb shifted = {sreg_q[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      always_comb shifted = {data_in, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state logic: bit counting, shifting and word completion; clr wins over en.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    complete = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sreg_d  = '0;
    end else if (en) begin
      sreg_d = shifted;
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output holding register: transfer on valid&&ready, load or drop a completed word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
    // A completion on the same edge as a transfer re-asserts valid with the new word.
    if (complete) begin
      if (!valid_q || ready_in) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clr) begin
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_ser_par_conv_hs.sv
// Bench for ser_par_conv_hs: three instances (8-bit LSB-first, 8-bit
// MSB-first, 32-bit LSB-first) share one stimulus stream and are compared
// every cycle against a bit-list reference model, plus directed literal checks.
module tb_ser_par_conv_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic ready_in = 1'b0;

  logic [7:0]  do_l, do_m;
  logic [31:0] do_w;
  logic        v_l, b_l, o_l, v_m, b_m, o_m, v_w, b_w, o_w;

  always #5 clk = ~clk;

  ser_par_conv_hs #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .data_in(data_in), .en(en), .clr(clr), .ready_in(ready_in),
    .data_out(do_l), .valid_out(v_l), .busy(b_l), .overrun(o_l));

  ser_par_conv_hs #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .data_in(data_in), .en(en), .clr(clr), .ready_in(ready_in),
    .data_out(do_m), .valid_out(v_m), .busy(b_m), .overrun(o_m));

  ser_par_conv_hs #(.WIDTH(32), .MSB_FIRST(1'b0)) u_w (
    .clk(clk), .rst(rst), .data_in(data_in), .en(en), .clr(clr), .ready_in(ready_in),
    .data_out(do_w), .valid_out(v_w), .busy(b_w), .overrun(o_w));

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: index 0 = 8/LSB, 1 = 8/MSB, 2 = 32/LSB.
  int          mw[3]  = '{8, 8, 32};
  bit          mmf[3] = '{1'b0, 1'b1, 1'b0};
  int          mcnt[3]   = '{0, 0, 0};
  bit          mbits[3][32];
  logic [31:0] mdout[3]  = '{32'd0, 32'd0, 32'd0};
  bit          mvalid[3] = '{1'b0, 1'b0, 1'b0};
  bit          movr[3]   = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mcnt[k] = 0; mdout[k] = '0; mvalid[k] = 1'b0; movr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit can_load;
        logic [31:0] w;
        can_load = !mvalid[k] || ready_in;
        if (mvalid[k] && ready_in) mvalid[k] = 1'b0;
        if (clr) begin
          mcnt[k] = 0;
          movr[k] = 1'b0;
        end else if (en) begin
          mbits[k][mcnt[k]] = data_in;
          mcnt[k]++;
          if (mcnt[k] == mw[k]) begin
            mcnt[k] = 0;
            w = '0;
            for (int i = 0; i < mw[k]; i++)
              w[mmf[k] ? (mw[k] - 1 - i) : i] = mbits[k][i];
            if (can_load) begin
              mdout[k]  = w;
              mvalid[k] = 1'b1;
            end else begin
              movr[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (run) begin
      chk("l_data",  32'(do_l), mdout[0]);
      chk("l_valid", 32'(v_l),  32'(mvalid[0]));
      chk("l_busy",  32'(b_l),  32'(mcnt[0] != 0));
      chk("l_ovr",   32'(o_l),  32'(movr[0]));
      chk("m_data",  32'(do_m), mdout[1]);
      chk("m_valid", 32'(v_m),  32'(mvalid[1]));
      chk("m_busy",  32'(b_m),  32'(mcnt[1] != 0));
      chk("m_ovr",   32'(o_m),  32'(movr[1]));
      chk("w_data",  do_w,      mdout[2]);
      chk("w_valid", 32'(v_w),  32'(mvalid[2]));
      chk("w_busy",  32'(b_w),  32'(mcnt[2] != 0));
      chk("w_ovr",   32'(o_w),  32'(movr[2]));
    end
  end

  task automatic cyc(input bit e, input bit d, input bit r, input bit c);
    @(negedge clk);
    en = e; data_in = d; ready_in = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [31:0] w, input int n, input bit msb,
                          input bit r, input bit gap);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = msb ? w[n-1-i] : w[i];
      cyc(1'b1, b, r, 1'b0);
      if (gap && i < n - 1) begin
        cyc(1'b0, 1'b0, r, 1'b0);
        chk("m_busy_gap", 32'(b_m), 32'd1);
      end
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_l_data", 32'(do_l), 32'd0);
    chk("rst_l_valid", 32'(v_l), 32'd0);
    chk("rst_l_busy", 32'(b_l), 32'd0);
    chk("rst_w_ovr", 32'(o_w), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // LSB-first A5, one-cycle valid pulse
    send_seq(32'hA5, 8, 1'b0, 1'b1, 1'b0);
    chk("a5_data", 32'(do_l), 32'hA5);
    chk("a5_valid", 32'(v_l), 32'd1);
    chk("a5_model", mdout[0], 32'hA5);
    chk("a5_msb_inst", 32'(do_m), 32'hA5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_valid_drop", 32'(v_l), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // MSB-first B1, contiguous then gapped
    send_seq(32'hB1, 8, 1'b1, 1'b1, 1'b0);
    chk("b1_data", 32'(do_m), 32'hB1);
    chk("b1_lsb_inst", 32'(do_l), 32'h8D);
    send_seq(32'hB1, 8, 1'b1, 1'b1, 1'b1);
    chk("b1g_data", 32'(do_m), 32'hB1);
    chk("b1g_valid", 32'(v_m), 32'd1);
    chk("b1g_busy_end", 32'(b_m), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // Back-pressure: second word dropped
    send_seq(32'h3C, 8, 1'b0, 1'b0, 1'b0);
    send_seq(32'hC3, 8, 1'b0, 1'b0, 1'b0);
    chk("bp_data", 32'(do_l), 32'h3C);
    chk("bp_valid", 32'(v_l), 32'd1);
    chk("bp_ovr", 32'(o_l), 32'd1);
    chk("bp_model_ovr", 32'(movr[0]), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_accept", 32'(v_l), 32'd0);
    chk("bp_hold", 32'(do_l), 32'h3C);

    // Transfer and completion on the same edge
    send_seq(32'h96, 8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w2;
      w2 = 8'h5E;
      cyc(1'b1, w2[i], (i == 7), 1'b0);
    end
    chk("sim_data", 32'(do_l), 32'h5E);
    chk("sim_valid", 32'(v_l), 32'd1);
    chk("sim_ovr_sticky", 32'(o_l), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sim_drop", 32'(v_l), 32'd0);

    // clr mid-word, then a clean word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(32'h5A, 8, 1'b0, 1'b0, 1'b0);
    chk("clr_data", 32'(do_l), 32'h5A);
    chk("clr_ovr", 32'(o_l), 32'd0);
    chk("clr_valid", 32'(v_l), 32'd1);

    // clr coincident with a final bit
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clrf_data", 32'(do_l), 32'h5A);
    chk("clrf_valid", 32'(v_l), 32'd1);
    chk("clrf_ovr", 32'(o_l), 32'd0);
    chk("clrf_busy", 32'(b_l), 32'd0);

    // 32-bit smoke word
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    send_seq(32'hDEADBEEF, 32, 1'b0, 1'b1, 1'b0);
    chk("w32_data", do_w, 32'hDEADBEEF);
    chk("w32_valid", 32'(v_w), 32'd1);
    chk("w32_l_last_byte", 32'(do_l), 32'hDE);

    // Async reset mid-word with a pending word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(v_w), 32'd1);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_l_data", 32'(do_l), 32'd0);
    chk("arst_l_valid", 32'(v_l), 32'd0);
    chk("arst_l_busy", 32'(b_l), 32'd0);
    chk("arst_w_data", do_w, 32'd0);
    chk("arst_w_valid", 32'(v_w), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) < 7);
      data_in  = 1'($urandom_range(0, 1));
      ready_in = ($urandom_range(0, 9) < 4);
      clr      = ($urandom_range(0, 99) == 0);
      rst      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #3;
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
